// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display codes and converter state encoding
package display_pkg;

   localparam logic [3:0]  BCD_BLANK    = 4'hA;
   localparam logic [3:0]  BCD_TRACO    = 4'hF;
   localparam int unsigned LIMITE_DUPLO = 99;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      MODULO   = 2'd1,
      CONVERTE = 2'd2,
      FINAL    = 2'd3
   } estado_t;

endpackage

// File: rtl/corrige_add3.sv
// rtl/corrige_add3.sv - double-dabble digit correction (add 3 when >= 5)
module corrige_add3 (
   input  logic [3:0] digito,
   output logic [3:0] corrigido
);

   assign corrigido = (digito >= 4'd5) ? (digito + 4'd3) : digito;

endmodule

// File: rtl/bin_para_bcd_duplo.sv
// rtl/bin_para_bcd_duplo.sv - signed binary to two-digit BCD converter, start/done handshake
module bin_para_bcd_duplo #(
   parameter int WIDTH        = 8,
   parameter bit SUPRIME_ZERO = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inicio,
   input  logic [WIDTH-1:0] valor,
   output logic             ocupado,
   output logic             pronto,
   output logic             estouro,
   output logic             sinal,
   output logic [3:0]       dezena,
   output logic [3:0]       unidade
);
   import display_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   estado_t          estado, estado_prox;
   logic [WIDTH-1:0] valor_q;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] mag_abs;
   logic [CW-1:0]    cont;
   logic [3:0]       d1, d0;
   logic [3:0]       d1_c, d0_c;
   logic             neg;
   logic             ovf;

   corrige_add3 u_corrige_d1 (.digito(d1), .corrigido(d1_c));
   corrige_add3 u_corrige_d0 (.digito(d0), .corrigido(d0_c));

   // Unsigned reinterpretation makes -2^(WIDTH-1) come out as 2^(WIDTH-1).
   assign mag_abs = valor_q[WIDTH-1] ? (-valor_q) : valor_q;
   assign ocupado = (estado != OCIOSO);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= OCIOSO;
      else        estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:   if (inicio) estado_prox = MODULO;
         MODULO:   estado_prox = CONVERTE;
         CONVERTE: if (cont == CW'(1)) estado_prox = FINAL;
         FINAL:    estado_prox = OCIOSO;
         default:  estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valor_q <= '0;
         mag     <= '0;
         cont    <= '0;
         d1      <= 4'd0;
         d0      <= 4'd0;
         neg     <= 1'b0;
         ovf     <= 1'b0;
         pronto  <= 1'b0;
         estouro <= 1'b0;
         sinal   <= 1'b0;
         dezena  <= BCD_BLANK;
         unidade <= BCD_BLANK;
      end else begin
         pronto <= 1'b0;
         case (estado)
            OCIOSO: if (inicio) valor_q <= valor;
            MODULO: begin
               neg  <= valor_q[WIDTH-1];
               mag  <= mag_abs;
               ovf  <= ({{(32-WIDTH){1'b0}}, mag_abs} > LIMITE_DUPLO);
               d1   <= 4'd0;
               d0   <= 4'd0;
               cont <= CW'(WIDTH);
            end
            CONVERTE: begin
               // Carry out of d1 is dropped; such values are already flagged by ovf.
               d1   <= {d1_c[2:0], d0_c[3]};
               d0   <= {d0_c[2:0], mag[WIDTH-1]};
               mag  <= {mag[WIDTH-2:0], 1'b0};
               cont <= cont - CW'(1);
            end
            FINAL: begin
               pronto <= 1'b1;
               if (ovf) begin
                  dezena  <= BCD_TRACO;
                  unidade <= BCD_TRACO;
                  sinal   <= 1'b0;
                  estouro <= 1'b1;
               end else begin
                  dezena  <= (SUPRIME_ZERO && d1 == 4'd0) ? BCD_BLANK : d1;
                  unidade <= d0;
                  sinal   <= neg;
                  estouro <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_para_bcd_duplo.sv
// tb/tb_bin_para_bcd_duplo.sv - directed bench for bin_para_bcd_duplo (8-bit both blanking modes, 16-bit)
module tb_bin_para_bcd_duplo;

   typedef struct {
      logic [7:0] valor;
      logic       sinal;
      logic [3:0] dez_sz1;
      logic [3:0] dez_sz0;
      logic [3:0] uni;
      logic       est;
   } vetor_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        inicio8;
   logic [7:0]  valor8;
   logic        inicio16;
   logic [15:0] valor16;

   logic       ocupado_a, pronto_a, estouro_a, sinal_a;
   logic [3:0] dezena_a, unidade_a;
   logic       ocupado_b, pronto_b, estouro_b, sinal_b;
   logic [3:0] dezena_b, unidade_b;
   logic       ocupado_c, pronto_c, estouro_c, sinal_c;
   logic [3:0] dezena_c, unidade_c;

   int n_checks = 0;
   int n_fail   = 0;

   bin_para_bcd_duplo #(.WIDTH(8), .SUPRIME_ZERO(1'b1)) dut_a (
      .clock(clock), .reset(reset), .inicio(inicio8), .valor(valor8),
      .ocupado(ocupado_a), .pronto(pronto_a), .estouro(estouro_a),
      .sinal(sinal_a), .dezena(dezena_a), .unidade(unidade_a));

   bin_para_bcd_duplo #(.WIDTH(8), .SUPRIME_ZERO(1'b0)) dut_b (
      .clock(clock), .reset(reset), .inicio(inicio8), .valor(valor8),
      .ocupado(ocupado_b), .pronto(pronto_b), .estouro(estouro_b),
      .sinal(sinal_b), .dezena(dezena_b), .unidade(unidade_b));

   bin_para_bcd_duplo #(.WIDTH(16), .SUPRIME_ZERO(1'b1)) dut_c (
      .clock(clock), .reset(reset), .inicio(inicio16), .valor(valor16),
      .ocupado(ocupado_c), .pronto(pronto_c), .estouro(estouro_c),
      .sinal(sinal_c), .dezena(dezena_c), .unidade(unidade_c));

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_checks++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   // Starts one 8-bit conversion and returns the edge count to pronto (-1 on timeout).
   task automatic run8(input logic [7:0] v, output int lat);
      @(posedge clock); #1;
      valor8  = v;
      inicio8 = 1'b1;
      @(posedge clock); #1;
      inicio8 = 1'b0;
      check("ocupado_after_accept", ocupado_a, 1);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (pronto_a) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run16(input logic [15:0] v, output int lat);
      @(posedge clock); #1;
      valor16  = v;
      inicio16 = 1'b1;
      @(posedge clock); #1;
      inicio16 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (pronto_c) begin
            lat = i;
            break;
         end
      end
   endtask

   vetor_t tabela [11];

   initial begin
      int lat;
      int npronto;
      int t_pronto [3];
      int k;
      int mudancas;
      logic [3:0] dez_ref, uni_ref;

      tabela[0]  = '{8'd57,  1'b0, 4'd5, 4'd5, 4'd7, 1'b0};
      tabela[1]  = '{8'hF7,  1'b1, 4'hA, 4'd0, 4'd9, 1'b0};
      tabela[2]  = '{8'd99,  1'b0, 4'd9, 4'd9, 4'd9, 1'b0};
      tabela[3]  = '{8'd100, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1};
      tabela[4]  = '{8'h80,  1'b0, 4'hF, 4'hF, 4'hF, 1'b1};
      tabela[5]  = '{8'd0,   1'b0, 4'hA, 4'd0, 4'd0, 1'b0};
      tabela[6]  = '{8'h9D,  1'b1, 4'd9, 4'd9, 4'd9, 1'b0};
      tabela[7]  = '{8'd10,  1'b0, 4'd1, 4'd1, 4'd0, 1'b0};
      tabela[8]  = '{8'h7F,  1'b0, 4'hF, 4'hF, 4'hF, 1'b1};
      tabela[9]  = '{8'h9C,  1'b0, 4'hF, 4'hF, 4'hF, 1'b1};
      tabela[10] = '{8'd5,   1'b0, 4'hA, 4'd0, 4'd5, 1'b0};

      reset    = 1'b0;
      inicio8  = 1'b0;
      valor8   = 8'd0;
      inicio16 = 1'b0;
      valor16  = 16'd0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_dezena",  dezena_a,  4'hA);
      check("rst_unidade", unidade_a, 4'hA);
      check("rst_sinal",   sinal_a,   0);
      check("rst_pronto",  pronto_a,  0);
      check("rst_ocupado", ocupado_a, 0);
      check("rst_estouro", estouro_a, 0);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run8(tabela[i].valor, lat);
         check($sformatf("lat8[%0d]", i), lat, 10);
         check($sformatf("pronto_b[%0d]", i), pronto_b, 1);
         check($sformatf("ocupado_at_pronto[%0d]", i), ocupado_a, 0);
         check($sformatf("sinal_a[%0d]", i), sinal_a, tabela[i].sinal);
         check($sformatf("dezena_a[%0d]", i), dezena_a, tabela[i].dez_sz1);
         check($sformatf("unidade_a[%0d]", i), unidade_a, tabela[i].uni);
         check($sformatf("estouro_a[%0d]", i), estouro_a, tabela[i].est);
         check($sformatf("sinal_b[%0d]", i), sinal_b, tabela[i].sinal);
         check($sformatf("dezena_b[%0d]", i), dezena_b, tabela[i].dez_sz0);
         check($sformatf("unidade_b[%0d]", i), unidade_b, tabela[i].uni);
         @(posedge clock); #1;
         check($sformatf("pronto_pulse[%0d]", i), pronto_a, 0);
      end

      // Reset asserted mid-conversion: immediate blank, no pronto afterwards
      run8(8'd57, lat);
      @(posedge clock); #1;
      valor8  = 8'd57;
      inicio8 = 1'b1;
      @(posedge clock); #1;
      inicio8 = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_dezena",  dezena_a,  4'hA);
      check("midrst_unidade", unidade_a, 4'hA);
      check("midrst_sinal",   sinal_a,   0);
      check("midrst_ocupado", ocupado_a, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      npronto = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (pronto_a) npronto++;
      end
      check("midrst_no_pronto", npronto, 0);

      // inicio pulsed while busy is ignored
      @(posedge clock); #1;
      valor8  = 8'd57;
      inicio8 = 1'b1;
      @(posedge clock); #1;
      inicio8 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      valor8  = 8'd99;
      inicio8 = 1'b1;
      @(posedge clock); #1;
      inicio8 = 1'b0;
      npronto = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clock); #1;
         if (pronto_a) npronto++;
      end
      check("busy_one_pronto", npronto, 1);
      check("busy_dezena",  dezena_a,  4'd5);
      check("busy_unidade", unidade_a, 4'd7);

      // inicio held high: back-to-back conversions, outputs stable between pulses
      @(posedge clock); #1;
      valor8  = 8'd42;
      inicio8 = 1'b1;
      k = 0;
      mudancas = 0;
      dez_ref = 4'd0;
      uni_ref = 4'd0;
      for (int i = 1; i <= 36; i++) begin
         @(posedge clock); #1;
         if (k > 0 && (dezena_a !== dez_ref || unidade_a !== uni_ref)) mudancas++;
         if (pronto_a && k < 3) begin
            t_pronto[k] = i;
            k++;
            dez_ref = dezena_a;
            uni_ref = unidade_a;
         end
      end
      inicio8 = 1'b0;
      check("held_count", k, 3);
      check("held_first", t_pronto[0], 11);
      check("held_gap1", t_pronto[1] - t_pronto[0], 11);
      check("held_gap2", t_pronto[2] - t_pronto[1], 11);
      check("held_stable", mudancas, 0);
      check("held_dezena", dezena_a, 4'd4);
      check("held_unidade", unidade_a, 4'd2);
      repeat (15) @(posedge clock);

      // 16-bit instance
      run16(16'hFFD6, lat);
      check("w16_lat", lat, 18);
      check("w16_sinal", sinal_c, 1);
      check("w16_dezena", dezena_c, 4'd4);
      check("w16_unidade", unidade_c, 4'd2);
      check("w16_estouro", estouro_c, 0);
      run16(16'd1234, lat);
      check("w16_ovf_lat", lat, 18);
      check("w16_ovf_dezena", dezena_c, 4'hF);
      check("w16_ovf_estouro", estouro_c, 1);
      run16(16'h8000, lat);
      check("w16_min_unidade", unidade_c, 4'hF);
      check("w16_min_sinal", sinal_c, 0);
      run16(16'd90, lat);
      check("w16_90_dezena", dezena_c, 4'd9);
      check("w16_90_unidade", unidade_c, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_para_bcd_duplo.md
Name: bin_para_bcd_duplo

Overview:
Sequential signed-binary to two-digit BCD converter. It feeds the two-digit 7-segment decoder, producing exactly the `sinal` / `dezena` / `unidade` codes that decoder expects.
Conversion uses iterative shift-add-3 (double-dabble) under a start/done handshake.
It sits between the CPU output register (OUT instruction) and the display decoder.
Out-of-range magnitudes display as "--"; a leading zero is optionally blanked.

Parameters:
WIDTH, 8, width of the signed two's-complement input; legal range 4..16.
SUPRIME_ZERO, 1, 1 = tens digit shows blank code when |valor| < 10; 0 = shows 0.

Ports:
clock  input  1  single system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
inicio  input  1  start request, sampled only in OCIOSO.
valor  input  WIDTH  signed operand, captured on the accepted `inicio` edge.
ocupado  output  1  high from the cycle after acceptance until `pronto`.
pronto  output  1  one-cycle pulse; result outputs valid from this cycle on.
estouro  output  1  |valor| > 99 for the last completed conversion.
sinal  output  1  1 = negative result.
dezena  output  4  tens code: 0-9, 4'hA blank, 4'hF dash.
unidade  output  4  units code: 0-9, 4'hF dash.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - state := OCIOSO; `ocupado` = `pronto` = `estouro` = `sinal` = 0.
  - `dezena` = `unidade` = 4'hA (blank display).
  - Any conversion in progress is aborted; no `pronto` is issued.
- FSM states: OCIOSO, MODULO, CONVERTE, FINAL.
- OCIOSO:
  - On `inicio` = 1, capture `valor` and go to MODULO.
  - `inicio` is ignored in every other state; there is no queueing.
- MODULO (1 cycle):
  - Latch `neg` = `valor[WIDTH-1]`.
  - Magnitude `mag` = neg ? -valor : valor, computed at WIDTH bits as unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) with no wrap.
  - Latch `ovf` = (mag > 99).
  - Clear the BCD register {d1, d0}; load iteration counter := WIDTH.
- CONVERTE (exactly WIDTH cycles):
  - Each cycle, add 3 to each of d1 and d0 if it is >= 5.
  - Then shift {d1, d0, mag} left by 1.
  - Bits shifted out of d1 are discarded; `ovf` overrides the result in that case.
  - Decrement the counter; leave when it reaches 1.
- FINAL (1 cycle):
  - Register the outputs, pulse `pronto`, return to OCIOSO.
  - If `ovf`: `dezena` = `unidade` = 4'hF, `sinal` = 0, `estouro` = 1.
  - Else: `unidade` = d0, `sinal` = `neg`, `estouro` = 0.
  - Else, tens digit: `dezena` = (SUPRIME_ZERO && d1 == 0) ? 4'hA : d1.
- Latency: acceptance edge to `pronto` = WIDTH + 2 cycles; throughput is one conversion per WIDTH + 3 cycles.
- `ocupado` = 1 in MODULO, CONVERTE and FINAL.
- Result outputs hold their values between conversions; they change only in FINAL or on reset.
- `inicio` held continuously: a new conversion is accepted in the cycle after FINAL (back in OCIOSO).
- Zero input: `sinal` = 0, `unidade` = 0, `dezena` = blank (SUPRIME_ZERO = 1) or 0. Negative zero cannot occur.

Decomposition:
- Shared package `display_pkg`:
  - Constants BCD_BLANK = 4'hA, BCD_TRACO = 4'hF, LIMITE_DUPLO = 99.
  - FSM state encoding (2 bits).
  - These are the same codes the display decoder interprets, so both blocks depend on one definition.
- One sub-module, `corrige_add3`: 4-bit combinational digit >= 5 ? digit + 3 : digit. Instantiated twice (d1, d0).

Test Plan:
1. Reset low mid-CONVERTE (`valor` = 8'd57, assert `reset` 3 cycles after `inicio`) -> outputs immediately `dezena` = `unidade` = 4'hA, `sinal` = 0; no `pronto` after release.
2. `valor` = 8'd57, `inicio` 1 cycle -> `pronto` exactly 10 cycles later; `sinal` = 0, `dezena` = 5, `unidade` = 7, `estouro` = 0.
3. `valor` = -8'd9 (8'hF7) -> `sinal` = 1, `dezena` = 4'hA, `unidade` = 9. Rerun with SUPRIME_ZERO = 0 -> `dezena` = 0.
4. Boundaries:
   - `valor` = 99 -> 9/9, `estouro` = 0.
   - `valor` = 100 -> `dezena` = `unidade` = 4'hF, `estouro` = 1.
   - `valor` = -128 -> dashes, `sinal` = 0, `estouro` = 1.
   - `valor` = 0 -> blank/0, `sinal` = 0.
5. Handshake:
   - `inicio` pulsed during `ocupado` -> ignored; exactly one `pronto`.
   - `inicio` held high -> back-to-back conversions, `pronto` every 11 cycles.
   - Outputs stable between `pronto` pulses.
6. WIDTH = 16, `valor` = -16'd42 -> `pronto` after 18 cycles; `sinal` = 1, `dezena` = 4, `unidade` = 2.
